// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage hazard scoreboard for the 5-stage core: stall/bubble/flush and EX operand forwarding.
// Optional macro FORWARD_EN: load-use-only stalls plus MA/WB forwarding; undefined = stall on any pending writer.
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [1:0]  id_r1,
    input  logic [1:0]  id_r2,
    input  logic        id_r1_used,
    input  logic        id_r2_used,
    input  logic [1:0]  id_dst,
    input  logic        id_wr_en,
    input  logic        id_is_load,
    input  logic        ex_branch_taken,
    output logic        stall_if,
    output logic        stall_id,
    output logic        bubble_ex,
    output logic        flush_if_id,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic [15:0] stall_cnt
);

    logic        ex_valid_q, ma_valid_q, wb_valid_q;
    logic        ex_valid_d;
    logic [1:0]  ex_dst_q, ma_dst_q, wb_dst_q;
    logic        ex_wr_q, ma_wr_q, wb_wr_q;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        hazard;

    // r0 is hardwired zero, so it never counts as a pending write.
    function automatic logic writes(input logic v, input logic w,
                                    input logic [1:0] d, input logic [1:0] r);
        return v & w & (d == r) & (r != 2'd0);
    endfunction

`ifdef FORWARD_EN
    logic        ex_load_q, ma_load_q;
    logic [1:0]  ex_r1_q, ex_r2_q;
    logic        ex_r1u_q, ex_r2u_q;

    // Only a load in EX can't be covered by forwarding; one bubble moves it to WB range.
    always_comb begin
        hazard = id_valid & ex_load_q &
                 ((id_r1_used & writes(ex_valid_q, ex_wr_q, ex_dst_q, id_r1)) |
                  (id_r2_used & writes(ex_valid_q, ex_wr_q, ex_dst_q, id_r2)));
    end

    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (!rst) begin
            if (ex_r1u_q && !ma_load_q && writes(ma_valid_q, ma_wr_q, ma_dst_q, ex_r1_q))
                fwd_a_sel = 2'b01;
            else if (ex_r1u_q && writes(wb_valid_q, wb_wr_q, wb_dst_q, ex_r1_q))
                fwd_a_sel = 2'b10;
            if (ex_r2u_q && !ma_load_q && writes(ma_valid_q, ma_wr_q, ma_dst_q, ex_r2_q))
                fwd_b_sel = 2'b01;
            else if (ex_r2u_q && writes(wb_valid_q, wb_wr_q, wb_dst_q, ex_r2_q))
                fwd_b_sel = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        ex_load_q <= id_is_load;
        ma_load_q <= ex_load_q;
        ex_r1_q   <= id_r1;
        ex_r2_q   <= id_r2;
        ex_r1u_q  <= id_r1_used;
        ex_r2u_q  <= id_r2_used;
    end
`else
    logic unused_is_load;
    assign unused_is_load = id_is_load;

    // No bypass at all: the source must have left WB before ID may proceed.
    always_comb begin
        hazard = id_valid &
                 ((id_r1_used & (writes(ex_valid_q, ex_wr_q, ex_dst_q, id_r1) |
                                 writes(ma_valid_q, ma_wr_q, ma_dst_q, id_r1) |
                                 writes(wb_valid_q, wb_wr_q, wb_dst_q, id_r1))) |
                  (id_r2_used & (writes(ex_valid_q, ex_wr_q, ex_dst_q, id_r2) |
                                 writes(ma_valid_q, ma_wr_q, ma_dst_q, id_r2) |
                                 writes(wb_valid_q, wb_wr_q, wb_dst_q, id_r2))));
    end

    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
`endif

    // A taken branch kills the ID instruction, which overrides any stall it would cause.
    always_comb begin
        flush_if_id = ~rst & ex_branch_taken;
        stall_if    = ~rst & hazard & ~ex_branch_taken;
        stall_id    = stall_if;
        bubble_ex   = ~rst & (hazard | ex_branch_taken);
        ex_valid_d  = id_valid & ~bubble_ex;
        stall_cnt_d = stall_cnt_q;
        if (stall_if && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ma_valid_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ma_valid_q  <= ex_valid_q;
            wb_valid_q  <= ma_valid_q;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        ex_dst_q <= id_dst;
        ex_wr_q  <= id_wr_en;
        ma_dst_q <= ex_dst_q;
        ma_wr_q  <= ex_wr_q;
        wb_dst_q <= ma_dst_q;
        wb_wr_q  <= ma_wr_q;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expectations follow FORWARD_EN the same way the design build does.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_r1_used, id_r2_used, id_wr_en, id_is_load, ex_branch_taken;
    logic [1:0]  id_r1, id_r2, id_dst;
    logic        stall_if, stall_id, bubble_ex, flush_if_id;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = 16'd0;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_r1(id_r1), .id_r2(id_r2),
        .id_r1_used(id_r1_used), .id_r2_used(id_r2_used), .id_dst(id_dst),
        .id_wr_en(id_wr_en), .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
        .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
        .flush_if_id(flush_if_id), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic s, input logic b, input logic f);
        chk({tag, "_stall_if"}, {15'd0, stall_if}, {15'd0, s});
        chk({tag, "_stall_id"}, {15'd0, stall_id}, {15'd0, s});
        chk({tag, "_bubble"},   {15'd0, bubble_ex}, {15'd0, b});
        chk({tag, "_flush"},    {15'd0, flush_if_id}, {15'd0, f});
    endtask

    task automatic id_set(input logic v, input logic [1:0] r1, input logic u1,
                          input logic [1:0] r2, input logic u2,
                          input logic [1:0] d, input logic w, input logic ld);
        id_valid = v; id_r1 = r1; id_r1_used = u1; id_r2 = r2; id_r2_used = u2;
        id_dst = d; id_wr_en = w; id_is_load = ld;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drain();
        id_set(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc();
    endtask

    initial begin
        // reset: branch input high during reset must not leak out
        rst = 1'b1;
        ex_branch_taken = 1'b1;
        id_set(1, 1, 1, 2, 1, 3, 1, 0);
        cyc(); cyc(); settle();
        chk_ctl("rst_hold", 0, 0, 0);
        chk("rst_fwd_a", {14'd0, fwd_a_sel}, 16'd0);
        chk("rst_fwd_b", {14'd0, fwd_b_sel}, 16'd0);
        chk("rst_cnt", stall_cnt, 16'd0);
        ex_branch_taken = 1'b0;
        rst = 1'b0;
        id_set(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk_ctl("post_rst", 0, 0, 0);
        cyc();

        // ALU RAW: I1 writes r1, I2 reads r1 directly behind it
        id_set(1, 0, 0, 0, 0, 1, 1, 0); settle();
        chk_ctl("t1_i1", 0, 0, 0);
        cyc();
        id_set(1, 1, 1, 0, 0, 2, 1, 0); settle();
`ifdef FORWARD_EN
        chk_ctl("t1_i2", 0, 0, 0);
`else
        for (int i = 0; i < 3; i++) begin
            chk_ctl("t1_stall", 1, 1, 0);
            cyc(); settle();
        end
        chk_ctl("t1_go", 0, 0, 0);
        exp_cnt = exp_cnt + 16'd3;
`endif
        cyc();
        id_set(0, 0, 0, 0, 0, 0, 0, 0); settle();
`ifdef FORWARD_EN
        chk("t1_fwd_a", {14'd0, fwd_a_sel}, 16'd1);
`else
        chk("t1_fwd_a", {14'd0, fwd_a_sel}, 16'd0);
`endif
        chk("t1_fwd_b", {14'd0, fwd_b_sel}, 16'd0);
        chk("t1_cnt", stall_cnt, exp_cnt);
        drain();

        // load-use: LD r2, then ADD reads r2 on source b
        id_set(1, 0, 0, 0, 0, 2, 1, 1); settle();
        chk_ctl("t2_ld", 0, 0, 0);
        cyc();
        id_set(1, 0, 0, 2, 1, 3, 1, 0); settle();
`ifdef FORWARD_EN
        chk_ctl("t2_lu", 1, 1, 0);
        cyc(); settle();
        chk_ctl("t2_after", 0, 0, 0);
        exp_cnt = exp_cnt + 16'd1;
`else
        for (int i = 0; i < 3; i++) begin
            chk_ctl("t2_stall", 1, 1, 0);
            cyc(); settle();
        end
        chk_ctl("t2_go", 0, 0, 0);
        exp_cnt = exp_cnt + 16'd3;
`endif
        cyc();
        id_set(0, 0, 0, 0, 0, 0, 0, 0); settle();
`ifdef FORWARD_EN
        chk("t2_fwd_b", {14'd0, fwd_b_sel}, 16'd2);
`else
        chk("t2_fwd_b", {14'd0, fwd_b_sel}, 16'd0);
`endif
        chk("t2_fwd_a", {14'd0, fwd_a_sel}, 16'd0);
        chk("t2_cnt", stall_cnt, exp_cnt);
        drain();

        // r0 destination never hazards or forwards
        id_set(1, 0, 0, 0, 0, 0, 1, 1); settle();
        cyc();
        id_set(1, 0, 1, 0, 1, 1, 1, 0); settle();
        chk_ctl("t3_r0", 0, 0, 0);
        cyc();
        id_set(0, 0, 0, 0, 0, 0, 0, 0); settle();
        chk("t3_fwd_a", {14'd0, fwd_a_sel}, 16'd0);
        chk("t3_fwd_b", {14'd0, fwd_b_sel}, 16'd0);
        chk("t3_cnt", stall_cnt, exp_cnt);
        drain();

        // flush overrides a simultaneous load-use hazard
        id_set(1, 0, 0, 0, 0, 3, 1, 1); settle();
        cyc();
        id_set(1, 3, 1, 0, 0, 1, 1, 0);
        ex_branch_taken = 1'b1; settle();
        chk_ctl("t4_flush", 0, 1, 1);
        cyc();
        ex_branch_taken = 1'b0;
        id_set(0, 0, 0, 0, 0, 0, 0, 0); settle();
        chk("t4_cnt", stall_cnt, exp_cnt);
        chk_ctl("t4_next", 0, 0, 0);
        drain();

        // r3 written by both MA and WB; EX reads r3 on both sources
        id_set(1, 0, 0, 0, 0, 3, 1, 0); settle();
        cyc();
        id_set(1, 0, 0, 0, 0, 3, 1, 0); settle();
        cyc();
        id_set(1, 3, 1, 3, 1, 1, 1, 0); settle();
`ifdef FORWARD_EN
        chk_ctl("t5_id", 0, 0, 0);
`else
        for (int i = 0; i < 3; i++) begin
            chk_ctl("t5_stall", 1, 1, 0);
            cyc(); settle();
        end
        chk_ctl("t5_go", 0, 0, 0);
        exp_cnt = exp_cnt + 16'd3;
`endif
        cyc();
        id_set(0, 0, 0, 0, 0, 0, 0, 0); settle();
`ifdef FORWARD_EN
        chk("t5_fwd_a", {14'd0, fwd_a_sel}, 16'd1);
        chk("t5_fwd_b", {14'd0, fwd_b_sel}, 16'd1);
`else
        chk("t5_fwd_a", {14'd0, fwd_a_sel}, 16'd0);
        chk("t5_fwd_b", {14'd0, fwd_b_sel}, 16'd0);
`endif
        chk("t5_cnt", stall_cnt, exp_cnt);
        drain();

        // reset in the middle of a stall
        id_set(1, 0, 0, 0, 0, 1, 1, 1); settle();
        cyc();
        id_set(1, 1, 1, 0, 0, 2, 1, 0); settle();
        chk_ctl("t6_s1", 1, 1, 0);
`ifndef FORWARD_EN
        cyc(); settle();
        chk_ctl("t6_s2", 1, 1, 0);
`endif
        rst = 1'b1; settle();
        chk_ctl("t6_rst", 0, 0, 0);
        cyc();
        rst = 1'b0; settle();
        chk("t6_cnt", stall_cnt, 16'd0);
        chk_ctl("t6_resume", 0, 0, 0);
        cyc();
        id_set(0, 0, 0, 0, 0, 0, 0, 0); settle();
        chk("t6_fwd_a", {14'd0, fwd_a_sel}, 16'd0);
        chk("t6_cnt_end", stall_cnt, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
